// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared types, default widths and helpers for the dmem arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Ownership FSM encoding: idle, or locked to port 0 / port 1.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam int c_aw_default       = 32;
    localparam int c_dw_default       = 32;
    localparam int c_lock_max_default = 16;

    // Byte address is misaligned when it does not point at a word boundary.
    function automatic logic f_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rr_arb2
// Description : Two-way round-robin grant with a "last granted" pointer.
//               Requests outside i_mask are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);

    logic [1:0] w_eff;
    logic       r_last;

    assign w_eff = i_req & i_mask;

    // On conflict the port that was not granted last time wins.
    always_comb begin
        o_gnt = 2'b00;
        case (w_eff)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Remember the most recently granted port; reset favours port 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port data memory between the CPU LSU (port 0)
//               and the debug/DMA loader (port 1). Round-robin on conflict,
//               lockable ownership with forced release, registered read data
//               and misalignment error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = c_aw_default,
    parameter int DW       = c_dw_default,
    parameter int LOCK_MAX = c_lock_max_default
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int c_cnt_w = $clog2(LOCK_MAX + 1);

    logic [1:0]         w_req, w_we, w_lock, w_mask, w_gnt, w_misal;
    logic [AW-1:0]      w_addr  [2];
    logic [DW-1:0]      w_wdata [2];
    state_t             r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic               w_own, w_any, w_sel;
    logic [AW-1:0]      r_hold_a;
    logic [DW-1:0]      r_hold_wd;

    assign w_req      = {p1_req, p0_req};
    assign w_we       = {p1_we, p0_we};
    assign w_lock     = {p1_lock, p0_lock};
    assign w_addr[0]  = p0_addr;
    assign w_addr[1]  = p1_addr;
    assign w_wdata[0] = p0_wdata;
    assign w_wdata[1] = p1_wdata;
    assign w_misal    = {f_misaligned(p1_addr[1:0]), f_misaligned(p0_addr[1:0])};

    // While a port owns the memory only that port may be granted.
    assign w_mask = (r_state == ST_OWN0) ? 2'b01 :
                    (r_state == ST_OWN1) ? 2'b10 : 2'b11;
    assign w_own  = (r_state == ST_OWN1);

    dmem_rr_arb2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (w_req),
        .i_mask  (w_mask),
        .o_gnt   (w_gnt)
    );

    assign p0_gnt = w_gnt[0];
    assign p1_gnt = w_gnt[1];

    // Ownership FSM: enter on a locked grant, leave when the owner drops lock
    // or after LOCK_MAX consecutive owned cycles.
    always_comb begin
        w_state_nxt    = r_state;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt[0] && p0_lock) begin
                    w_state_nxt    = ST_OWN0;
                    w_lock_cnt_nxt = c_cnt_w'(1);
                end else if (w_gnt[1] && p1_lock) begin
                    w_state_nxt    = ST_OWN1;
                    w_lock_cnt_nxt = c_cnt_w'(1);
                end
            end
            ST_OWN0, ST_OWN1: begin
                // A dropped lock releases whether or not the owner is requesting.
                if (!w_lock[w_own] || (r_lock_cnt >= c_cnt_w'(LOCK_MAX - 1))) begin
                    w_state_nxt    = ST_IDLE;
                    w_lock_cnt_nxt = '0;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_lock_cnt_nxt = '0;
            end
        endcase
    end

    // FSM state and lock counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    // Memory-side mux; address/data hold their last granted values when idle.
    assign w_any  = |w_gnt;
    assign w_sel  = w_gnt[1];
    assign mem_a  = w_any ? w_addr[w_sel]  : r_hold_a;
    assign mem_wd = w_any ? w_wdata[w_sel] : r_hold_wd;
    assign mem_we = reset_n & w_any & w_we[w_sel] & ~w_misal[w_sel];

    // Capture the granted address/data so the memory bus is stable when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_a  <= '0;
            r_hold_wd <= '0;
        end else if (w_any) begin
            r_hold_a  <= w_addr[w_sel];
            r_hold_wd <= w_wdata[w_sel];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_resp
        logic          r_rvalid;
        logic          r_err;
        logic [DW-1:0] r_rdata;

        // Per-port response: read data one cycle after grant, or an error pulse.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rvalid <= 1'b0;
                r_err    <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_rvalid <= w_gnt[g] & ~w_we[g] & ~w_misal[g];
                r_err    <= w_gnt[g] & w_misal[g];
                if (w_gnt[g] && !w_we[g] && !w_misal[g]) begin
                    r_rdata <= mem_rd;
                end
            end
        end
    end

    assign p0_rvalid = g_resp[0].r_rvalid;
    assign p0_err    = g_resp[0].r_err;
    assign p0_rdata  = g_resp[0].r_rdata;
    assign p1_rvalid = g_resp[1].r_rvalid;
    assign p1_err    = g_resp[1].r_err;
    assign p1_rdata  = g_resp[1].r_rdata;

endmodule
`default_nettype wire
